// File: rtl/horner_ctrl.sv
// rtl/horner_ctrl.sv - Horner-scheme polynomial evaluator with a coefficient bank
//
// Evaluates p(x) = sum coef[i] * x^i for i = 0..degree using Horner's rule.
// The multiplier is external and combinational: this block presents the
// operands on mul_x / mul_coeff and captures mul_out one cycle later.
// All arithmetic wraps modulo 2^W.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   coeff_we     coefficient write strobe (honoured only in IDLE without start)
//   coeff_addr   coefficient index; index i holds the coefficient of x^i
//   coeff_wdata  coefficient write data
//   start        evaluation request, sampled only in IDLE
//   degree       polynomial degree, latched on an accepted start
//   x            evaluation point, latched on an accepted start
//   mul_x        multiplier operand, the latched x (registered)
//   mul_coeff    multiplier operand, the accumulator (registered)
//   mul_out      product from the external multiplier, same cycle
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle completion pulse
//   result       registered polynomial value, held until the next completion
//   wr_drop      one-cycle pulse flagging a rejected coefficient write

module horner_ctrl #(
  parameter int N_COEF = 8,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         coeff_we,
  input  logic [2:0]   coeff_addr,
  input  logic [W-1:0] coeff_wdata,
  input  logic         start,
  input  logic [2:0]   degree,
  input  logic [W-1:0] x,
  output logic [W-1:0] mul_x,
  output logic [W-1:0] mul_coeff,
  input  logic [W-1:0] mul_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         wr_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] x_r;
  logic [W-1:0] acc;
  logic [W-1:0] prod;
  logic [W-1:0] result_r;
  logic [2:0]   idx;
  logic         done_r;
  logic         wr_drop_r;
  logic [W-1:0] coef [N_COEF];

  logic         addr_ok;
  logic         accept;
  logic         wr_ok;
  logic         wr_rej;
  logic [2:0]   idx_m1;
  logic [W-1:0] acc_next;

  assign busy      = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && start;

  // Out-of-range addresses vanish silently: neither written nor flagged.
  assign addr_ok   = (int'({29'd0, coeff_addr}) < N_COEF);

  // A write collides with an evaluation either while one is running or in
  // the very cycle one is accepted; in both cases the bank must stay frozen
  // so the running evaluation sees a consistent coefficient set.
  assign wr_ok     = coeff_we && addr_ok && !busy && !start;
  assign wr_rej    = coeff_we && addr_ok && (busy || start);

  assign idx_m1    = idx - 3'd1;
  // When idx==1 this is prod + coef[0], i.e. the final polynomial value.
  assign acc_next  = prod + coef[idx_m1];

  assign mul_x     = x_r;
  assign mul_coeff = acc;
  assign done      = done_r;
  assign result    = result_r;
  assign wr_drop   = wr_drop_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x_r       <= '0;
      acc       <= '0;
      prod      <= '0;
      result_r  <= '0;
      idx       <= '0;
      done_r    <= 1'b0;
      wr_drop_r <= 1'b0;
      for (int i = 0; i < N_COEF; i++) begin
        coef[i] <= '0;
      end
    end else begin
      done_r    <= 1'b0;
      wr_drop_r <= wr_rej;

      if (wr_ok) begin
        coef[coeff_addr] <= coeff_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_r <= x;
            idx <= degree;
            acc <= coef[degree];
            if (degree == 3'd0) begin
              // Constant polynomial: no multiply needed, finish immediately.
              result_r <= coef[0];
              done_r   <= 1'b1;
            end else begin
              state <= ST_MUL;
            end
          end
        end

        ST_MUL: begin
          prod  <= mul_out;
          state <= ST_ACC;
        end

        ST_ACC: begin
          acc <= acc_next;
          idx <= idx_m1;
          if (idx == 3'd1) begin
            result_r <= acc_next;
            done_r   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_MUL;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_ctrl.sv
// tb/tb_horner_ctrl.sv - scoreboard testbench for horner_ctrl

module tb_horner_ctrl;

  logic        clk;
  logic        rst_n;
  logic        coeff_we;
  logic [2:0]  coeff_addr;
  logic [31:0] coeff_wdata;
  logic        start;
  logic [2:0]  degree;
  logic [31:0] x;
  logic [31:0] mul_x;
  logic [31:0] mul_coeff;
  logic [31:0] mul_out;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        wr_drop;

  horner_ctrl #(.N_COEF(8), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .start(start), .degree(degree), .x(x),
    .mul_x(mul_x), .mul_coeff(mul_coeff), .mul_out(mul_out),
    .busy(busy), .done(done), .result(result), .wr_drop(wr_drop)
  );

  assign mul_out = mul_x * mul_coeff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] res;
  } exp_t;

  exp_t        exp_q[$];
  int          wr_q[$];
  logic [31:0] bank[8];
  logic [31:0] last_res;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference: direct power-series sum, wrapping at 32 bits.
  function automatic logic [31:0] poly(input int d, input logic [31:0] xv);
    logic [31:0] sum;
    logic [31:0] pw;
    sum = 32'd0;
    pw  = 32'd1;
    for (int i = 0; i <= d; i++) begin
      sum = sum + bank[i] * pw;
      pw  = pw * xv;
    end
    return sum;
  endfunction

  // Monitor: pops expectations whenever the DUT presents done / wr_drop.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = 32'd0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_missing: no done by cycle %0d, expected at %0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_extra: done=1 at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("result", result, e.res);
          last_res = e.res;
        end
      end else begin
        check("result_hold", result, last_res);
      end

      if (wr_q.size() > 0 && wr_q[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_drop_missing: none by cycle %0d, expected at %0d", cyc, wr_q[0]);
        void'(wr_q.pop_front());
      end
      if (wr_drop) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_drop_extra: wr_drop=1 at cycle %0d, expected 0", cyc);
        end else begin
          check("wr_drop_cycle", cyc, wr_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    coeff_we    = 1'b1;
    coeff_addr  = a[2:0];
    coeff_wdata = d;
    bank[a]     = d;
    step();
    coeff_we    = 1'b0;
  endtask

  task automatic issue(input int d, input logic [31:0] xv);
    start  = 1'b1;
    degree = d[2:0];
    x      = xv;
    exp_q.push_back('{cyc: cyc + 1 + 2 * d, res: poly(d, xv)});
    step();
    start  = 1'b0;
    if (d == 0) begin
      check("busy_deg0", {31'd0, busy}, 32'd0);
    end else begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("mul_x", mul_x, xv);
      check("mul_coeff", mul_coeff, bank[d]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: evaluation pending after %0d cycles, expected completion", n);
      exp_q.delete();
    end
    step();
  endtask

  task automatic run(input int d, input logic [31:0] xv);
    issue(d, xv);
    wait_idle();
  endtask

  initial begin
    int d;
    rst_n       = 1'b0;
    coeff_we    = 1'b0;
    coeff_addr  = 3'd0;
    coeff_wdata = 32'd0;
    start       = 1'b0;
    degree      = 3'd0;
    x           = 32'd0;
    last_res    = 32'd0;
    for (int i = 0; i < 8; i++) bank[i] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_mul_x", mul_x, 32'd0);
    check("rst_mul_coeff", mul_coeff, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic: 1 + 2x + 3x^2 at x=2
    wr(0, 32'd1); wr(1, 32'd2); wr(2, 32'd3);
    run(2, 32'd2);
    check("basic_result", result, 32'd17);

    // Degree zero
    wr(0, 32'h55);
    run(0, 32'd9);
    check("deg0_result", result, 32'h55);

    // Wrap
    wr(1, 32'h8000_0000); wr(0, 32'd1);
    run(1, 32'd2);
    check("wrap_result", result, 32'd1);

    // Busy rejection: start and write while busy are both ignored
    wr(0, 32'd7); wr(1, 32'd1); wr(2, 32'd2);
    issue(2, 32'd3);
    coeff_we    = 1'b1;
    coeff_addr  = 3'd0;
    coeff_wdata = 32'hFF;
    start       = 1'b1;
    degree      = 3'd0;
    x           = 32'd9;
    wr_q.push_back(cyc + 1);
    step();
    coeff_we = 1'b0;
    start    = 1'b0;
    wait_idle();
    check("busy_rej_result", result, 32'd28);
    run(0, 32'd0);
    check("busy_rej_coef0", result, 32'd7);

    // Write in the same cycle as an accepted start is dropped
    start       = 1'b1;
    degree      = 3'd1;
    x           = 32'd7;
    coeff_we    = 1'b1;
    coeff_addr  = 3'd1;
    coeff_wdata = 32'h1234;
    exp_q.push_back('{cyc: cyc + 3, res: poly(1, 32'd7)});
    wr_q.push_back(cyc + 1);
    step();
    start    = 1'b0;
    coeff_we = 1'b0;
    wait_idle();
    check("same_cyc_result", result, 32'd14);

    // Reset mid-run
    issue(2, 32'd4);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_mul_coeff", mul_coeff, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) bank[i] = 32'd0;
    #3;
    rst_n = 1'b1;
    step();
    run(2, 32'd5);
    check("midrst_after", result, 32'd0);

    // Full depth
    for (int i = 0; i < 8; i++) wr(i, 32'd1);
    run(7, 32'd1);
    check("full_result", result, 32'd8);

    // Randomized runs with occasional writes during busy
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 7), $urandom);
      d = $urandom_range(0, 7);
      issue(d, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 5)));
      if (d > 0 && $urandom_range(0, 2) == 0) begin
        coeff_we    = 1'b1;
        coeff_addr  = 3'($urandom_range(0, 7));
        coeff_wdata = $urandom;
        wr_q.push_back(cyc + 1);
        step();
        coeff_we = 1'b0;
      end
      wait_idle();
    end

    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("wr_q_empty", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
